// File: rtl/demux_lane_gather_pkg.sv
// -----------------------------------------------------------------------------
// phy_pkg
//
// Shared definitions for the PHY receive-path lane gather block.
//   - Default slot/byte width and default lane geometry.
//   - cnt_width(): width of a counter that must hold the values 0..n-1
//     (never narrower than 1 bit). Used for the per-lane slot counter and,
//     when PARTIAL_FLUSH_EN is defined, the per-lane idle-gap counter.
//   - Slot-index helpers: flattened output slot numbering is lane*RATIO+k.
// -----------------------------------------------------------------------------
package phy_pkg;

   localparam int DEFAULT_DATA_W    = 8;
   localparam int DEFAULT_IN_LANES  = 2;
   localparam int DEFAULT_RATIO     = 2;
   localparam int DEFAULT_FLUSH_GAP = 4;

   // Slot k = 0 always holds the oldest byte of a gathered word.
   localparam int FIRST_SLOT = 0;

   // Width of a counter holding 0..n-1; a single bit is the floor so that
   // degenerate sizes still yield a legal vector.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Flattened slot number of slot k in lane l.
   function automatic int slot_index(input int lane, input int k, input int ratio);
      return lane * ratio + k;
   endfunction

endpackage : phy_pkg

// File: rtl/demux_lane_gather_if.sv
// -----------------------------------------------------------------------------
// demux_lane_gather_if
//
// Bundle of the lane gather data path.
//   valid_in  [IN_LANES]               per-lane byte valid
//   data_in   [IN_LANES*DATA_W]        lane l at [l*DATA_W +: DATA_W]
//   valid_out [IN_LANES*RATIO]         slot valid, slot l*RATIO+k
//   data_out  [IN_LANES*RATIO*DATA_W]  slot l*RATIO+k at [(l*RATIO+k)*DATA_W +: DATA_W]
//
// Modports:
//   master - the lane deserialiser side (drives bytes, observes slots)
//   slave  - the gather block itself (consumes bytes, drives slots)
// -----------------------------------------------------------------------------
interface demux_lane_gather_if #(
   parameter int DATA_W   = 8,
   parameter int IN_LANES = 2,
   parameter int RATIO    = 2
) ();

   logic [IN_LANES-1:0]              valid_in;
   logic [IN_LANES*DATA_W-1:0]       data_in;
   logic [IN_LANES*RATIO-1:0]        valid_out;
   logic [IN_LANES*RATIO*DATA_W-1:0] data_out;

   modport master (
      output valid_in,
      output data_in,
      input  valid_out,
      input  data_out
   );

   modport slave (
      input  valid_in,
      input  data_in,
      output valid_out,
      output data_out
   );

endinterface : demux_lane_gather_if

// File: rtl/demux_gather_lane.sv
// -----------------------------------------------------------------------------
// demux_gather_lane
//
// One input lane of the gather block. Consecutive accepted bytes are stored
// into a RATIO-deep gather buffer (oldest in slot 0). When the byte filling
// the last slot is accepted, the whole word is copied into a separate output
// register and shown for exactly one cycle; all other cycles the outputs are
// zero. Idle cycles (valid_in = 0) leave the partial word untouched.
//
// Optional feature, macro PARTIAL_FLUSH_EN: an idle-gap counter runs while a
// partial word is held. After FLUSH_GAP consecutive idle cycles the filled
// slots are emitted (unfilled slots stay invalid and zero) and the lane
// restarts at slot 0. A byte arriving on that cycle wins and no flush occurs.
// Without the macro partial words are held indefinitely.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   valid_in   in   byte valid for this lane
//   data_in    in   DATA_W byte
//   valid_out  out  RATIO slot valids (one-cycle pulse)
//   data_out   out  RATIO*DATA_W slot data, slot k at [k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module demux_gather_lane
   import phy_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int RATIO     = DEFAULT_RATIO,
   parameter int FLUSH_GAP = DEFAULT_FLUSH_GAP
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid_in,
   input  logic [DATA_W-1:0]       data_in,
   output logic [RATIO-1:0]        valid_out,
   output logic [RATIO*DATA_W-1:0] data_out
);

   localparam int              CNT_W    = cnt_width(RATIO);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0]        cnt_q,  cnt_d;
   logic [DATA_W-1:0]       buf_q  [RATIO];
   logic [DATA_W-1:0]       buf_d  [RATIO];
   logic [RATIO-1:0]        vout_q, vout_d;
   logic [RATIO*DATA_W-1:0] dout_q, dout_d;

`ifdef PARTIAL_FLUSH_EN
   localparam int              GAP_W    = cnt_width(FLUSH_GAP);
   // Value of the gap counter on the FLUSH_GAP-th consecutive idle cycle.
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FLUSH_GAP - 1);

   logic [GAP_W-1:0] gap_q, gap_d;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch; outputs default to an empty,
      // zeroed slot set, which is what every non-emit cycle must show.
      cnt_d  = cnt_q;
      buf_d  = buf_q;
      vout_d = '0;
      dout_d = '0;
`ifdef PARTIAL_FLUSH_EN
      gap_d  = gap_q;
`endif

      if (valid_in) begin
         buf_d[cnt_q] = data_in;
`ifdef PARTIAL_FLUSH_EN
         gap_d = '0;
`endif
         if (cnt_q == CNT_LAST) begin
            // Word complete: publish the buffer including the byte just taken.
            // The output register is separate, so a byte arriving next cycle
            // may overwrite slot 0 of the buffer without disturbing the pulse.
            cnt_d  = '0;
            vout_d = '1;
            for (int k = 0; k < RATIO; k++) begin
               dout_d[k*DATA_W +: DATA_W] = buf_d[k];
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
`ifdef PARTIAL_FLUSH_EN
      else if (cnt_q != '0) begin
         if (gap_q == GAP_LAST) begin
            // Flush the filled slots 0..cnt-1; the rest stay invalid and zero.
            for (int k = 0; k < RATIO; k++) begin
               if (CNT_W'(k) < cnt_q) begin
                  vout_d[k]                  = 1'b1;
                  dout_d[k*DATA_W +: DATA_W] = buf_q[k];
               end
            end
            cnt_d = '0;
            gap_d = '0;
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         vout_q <= '0;
         dout_q <= '0;
         // NOTE: the gather buffer is cleared on reset as well; it is small,
         // and a reset must leave no stale partial-word bytes behind.
         for (int k = 0; k < RATIO; k++) begin
            buf_q[k] <= '0;
         end
`ifdef PARTIAL_FLUSH_EN
         gap_q  <= '0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         buf_q  <= buf_d;
         vout_q <= vout_d;
         dout_q <= dout_d;
`ifdef PARTIAL_FLUSH_EN
         gap_q  <= gap_d;
`endif
      end
   end

   assign valid_out = vout_q;
   assign data_out  = dout_q;

endmodule : demux_gather_lane

// File: rtl/demux_lane_gather.sv
// -----------------------------------------------------------------------------
// demux_lane_gather
//
// Parametrised lane gather for the PHY receive path. Each of IN_LANES input
// byte lanes is gathered independently into RATIO consecutive valid bytes,
// which appear in parallel on that lane's RATIO output slots for one cycle,
// one clock after the last byte is sampled. Gaps in a lane's valid are
// transparent. There is no backpressure.
//
// Optional feature: define PARTIAL_FLUSH_EN to flush a partial word after
// FLUSH_GAP consecutive idle cycles on its lane.
//
// Parameters: DATA_W (slot width), IN_LANES, RATIO (>= 2), FLUSH_GAP.
// The interface instance must be built with the same DATA_W/IN_LANES/RATIO.
//
// Ports:
//   clk    in     single clock, all logic on posedge
//   reset  in     synchronous active-high reset; discards partial words
//   bus    slave  valid_in/data_in in, valid_out/data_out out
//                 (slot l*RATIO+k at [(l*RATIO+k)*DATA_W +: DATA_W])
// -----------------------------------------------------------------------------
module demux_lane_gather
   import phy_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int IN_LANES  = DEFAULT_IN_LANES,
   parameter int RATIO     = DEFAULT_RATIO,
   parameter int FLUSH_GAP = DEFAULT_FLUSH_GAP
) (
   input  logic              clk,
   input  logic              reset,
   demux_lane_gather_if.slave bus
);

   // Per-lane results, gathered into the flat output vectors below.
   logic [RATIO-1:0]        lane_vout [IN_LANES];
   logic [RATIO*DATA_W-1:0] lane_dout [IN_LANES];

   for (genvar l = 0; l < IN_LANES; l++) begin : g_lane
      demux_gather_lane #(
         .DATA_W    (DATA_W),
         .RATIO     (RATIO),
         .FLUSH_GAP (FLUSH_GAP)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .valid_in  (bus.valid_in[l]),
         .data_in   (bus.data_in[l*DATA_W +: DATA_W]),
         .valid_out (lane_vout[l]),
         .data_out  (lane_dout[l])
      );
   end

   always_comb begin
      bus.valid_out = '0;
      bus.data_out  = '0;
      for (int l = 0; l < IN_LANES; l++) begin
         bus.valid_out[slot_index(l, FIRST_SLOT, RATIO) +: RATIO] = lane_vout[l];
         bus.data_out[slot_index(l, FIRST_SLOT, RATIO)*DATA_W +: RATIO*DATA_W] =
            lane_dout[l];
      end
   end

endmodule : demux_lane_gather
